// File: rtl/ins_decode_unit_if.sv
// ins_decode_unit_if: bundles the fetch-side, write-back and ID/EX signals of
// the decode stage.
//   master : fetch / write-back / testbench side (drives *_in, reads *_out)
//   slave  : the decode unit itself
interface ins_decode_unit_if #(
  parameter int reg_width = 32,
  parameter int bus_width = 32,
  parameter int reg_count = 32
);
  localparam int aw = $clog2(reg_count);

  logic [bus_width-1:0] ins_in;
  logic [bus_width-1:0] npc_in;
  logic                 valid_in;
  logic                 freeze_in;
  logic                 flush_in;
  logic                 wb_en_in;
  logic [aw-1:0]        wb_addr_in;
  logic [reg_width-1:0] wb_data_in;

  logic                 stall_out;
  logic                 valid_out;
  logic [5:0]           opcode_out;
  logic [4:0]           rd_out;
  logic [reg_width-1:0] a_out;
  logic [reg_width-1:0] b_out;
  logic [reg_width-1:0] imm_out;
  logic [bus_width-1:0] npc_out;

  modport master (
    output ins_in, npc_in, valid_in, freeze_in, flush_in,
           wb_en_in, wb_addr_in, wb_data_in,
    input  stall_out, valid_out, opcode_out, rd_out,
           a_out, b_out, imm_out, npc_out
  );

  modport slave (
    input  ins_in, npc_in, valid_in, freeze_in, flush_in,
           wb_en_in, wb_addr_in, wb_data_in,
    output stall_out, valid_out, opcode_out, rd_out,
           a_out, b_out, imm_out, npc_out
  );
endinterface

// File: rtl/ins_decode_unit.sv
// ins_decode_unit: instruction decode pipeline stage.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : fetch inputs (ins/npc/valid/freeze/flush), register
//                  write-back port, stall_out to fetch, registered ID/EX
//                  outputs (valid, opcode, rd, a, b, imm, npc).
// Holds an IF/ID register, decodes it, reads the register file (with
// write-through bypass) and registers the result into ID/EX. A load in ID/EX
// whose destination is read by the IF/ID instruction stalls for one cycle.
module ins_decode_unit #(
  parameter int reg_width = 32,
  parameter int bus_width = 32,
  parameter int reg_count = 32
) (
  input logic             clock,
  input logic             reset,
  ins_decode_unit_if.slave bus
);
  localparam int aw = $clog2(reg_count);

  localparam logic [5:0] op_ralu   = 6'h00;
  localparam logic [5:0] op_ialu   = 6'h08;
  localparam logic [5:0] op_load   = 6'h20;
  localparam logic [5:0] op_store  = 6'h28;
  localparam logic [5:0] op_branch = 6'h04;
  localparam logic [5:0] op_jump   = 6'h02;

  // IF/ID
  logic [bus_width-1:0] ifid_ins_q, ifid_ins_d;
  logic [bus_width-1:0] ifid_npc_q, ifid_npc_d;
  logic                 ifid_vld_q, ifid_vld_d;

  // ID/EX
  logic                 valid_q, valid_d;
  logic [5:0]           opcode_q, opcode_d;
  logic [4:0]           rd_q, rd_d;
  logic [reg_width-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [bus_width-1:0] npc_q, npc_d;

  logic [reg_width-1:0] regs_q [reg_count];
  logic [reg_width-1:0] regs_d [reg_count];

  // Decode of the IF/ID instruction
  logic [5:0]           opc;
  logic [4:0]           rs1, rs2;
  logic                 use_rs1, use_rs2;
  logic [4:0]           dec_rd;
  logic [reg_width-1:0] dec_imm, rdata_a, rdata_b;
  logic                 stall;

  assign opc = ifid_ins_q[31:26];
  assign rs1 = ifid_ins_q[25:21];
  assign rs2 = ifid_ins_q[20:16];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec_rd  = '0;
    dec_imm = '0;
    case (opc)
      op_ralu: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_rd  = ifid_ins_q[15:11];
      end
      op_ialu, op_load: begin
        use_rs1 = 1'b1;
        dec_rd  = ifid_ins_q[20:16];
        dec_imm = {{(reg_width-16){ifid_ins_q[15]}}, ifid_ins_q[15:0]};
      end
      op_store: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{(reg_width-16){ifid_ins_q[15]}}, ifid_ins_q[15:0]};
      end
      op_branch: begin
        use_rs1 = 1'b1;
        dec_imm = {{(reg_width-16){ifid_ins_q[15]}}, ifid_ins_q[15:0]};
      end
      op_jump: dec_imm = {{(reg_width-26){ifid_ins_q[25]}}, ifid_ins_q[25:0]};
      default: ; // unknown opcode travels as a NOP
    endcase
  end

  // Register read; a same-cycle write-back to the read address wins.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (rs1 != '0) begin
      if (bus.wb_en_in && bus.wb_addr_in == rs1[aw-1:0]) rdata_a = bus.wb_data_in;
      else                                                rdata_a = regs_q[rs1[aw-1:0]];
    end
    if (rs2 != '0) begin
      if (bus.wb_en_in && bus.wb_addr_in == rs2[aw-1:0]) rdata_b = bus.wb_data_in;
      else                                                rdata_b = regs_q[rs2[aw-1:0]];
    end
  end

  // Load-use hazard: the bubble it inserts clears valid_q, so it self-ends.
  assign stall = ifid_vld_q && valid_q && (opcode_q == op_load) && (rd_q != '0) &&
                 ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));

  always_comb begin
    ifid_ins_d = ifid_ins_q;
    ifid_npc_d = ifid_npc_q;
    ifid_vld_d = ifid_vld_q;
    if (bus.flush_in) begin
      ifid_vld_d = 1'b0;
    end else if (!stall && !bus.freeze_in) begin
      ifid_ins_d = bus.ins_in;
      ifid_npc_d = bus.npc_in;
      ifid_vld_d = bus.valid_in;
    end else if (!stall) begin
      // Frozen: IF/ID moves to ID/EX this edge, so mark it consumed to
      // avoid issuing the same instruction twice.
      ifid_vld_d = 1'b0;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    npc_d    = npc_q;
    if (bus.flush_in || stall) begin
      valid_d = 1'b0;
    end else begin
      valid_d  = ifid_vld_q;
      opcode_d = opc;
      rd_d     = dec_rd;
      a_d      = rdata_a;
      b_d      = rdata_b;
      imm_d    = dec_imm;
      npc_d    = ifid_npc_q;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en_in && bus.wb_addr_in != '0) regs_d[bus.wb_addr_in] = bus.wb_data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_ins_q <= '0;
      ifid_npc_q <= '0;
      ifid_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      npc_q      <= '0;
      for (int i = 0; i < reg_count; i++) regs_q[i] <= '0;
    end else begin
      ifid_ins_q <= ifid_ins_d;
      ifid_npc_q <= ifid_npc_d;
      ifid_vld_q <= ifid_vld_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      npc_q      <= npc_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.stall_out  = stall;
  assign bus.valid_out  = valid_q;
  assign bus.opcode_out = opcode_q;
  assign bus.rd_out     = rd_q;
  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.imm_out    = imm_q;
  assign bus.npc_out    = npc_q;
endmodule

// File: tb/tb_ins_decode_unit.sv
module tb_ins_decode_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ins_decode_unit_if bus ();
  ins_decode_unit dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] a, b, imm, npc;
    bit          ca, cb, ci;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rd,
                              input logic [31:0] a, b, imm, npc, input bit ca, cb, ci);
    exp_t e;
    e.op = op; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.npc = npc;
    e.ca = ca; e.cb = cb; e.ci = ci;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] npc, input logic v);
    bus.ins_in   = ins;
    bus.npc_in   = npc;
    bus.valid_in = v;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en_in   = en;
    bus.wb_addr_in = addr;
    bus.wb_data_in = data;
  endtask

  // Scoreboard side: every valid ID/EX result must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("opcode", 32'(bus.opcode_out), 32'(e.op));
        chk("rd",     32'(bus.rd_out),     32'(e.rd));
        chk("npc",    bus.npc_out,         e.npc);
        if (e.ca) chk("a_out",   bus.a_out,   e.a);
        if (e.cb) chk("b_out",   bus.b_out,   e.b);
        if (e.ci) chk("imm_out", bus.imm_out, e.imm);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    monitor();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"},  32'(bus.stall_out),  32'd0);
    chk({tag, "_valid"},  32'(bus.valid_out),  32'd0);
    chk({tag, "_opcode"}, 32'(bus.opcode_out), 32'd0);
    chk({tag, "_rd"},     32'(bus.rd_out),     32'd0);
    chk({tag, "_a"},      bus.a_out,           32'd0);
    chk({tag, "_b"},      bus.b_out,           32'd0);
    chk({tag, "_imm"},    bus.imm_out,         32'd0);
    chk({tag, "_npc"},    bus.npc_out,         32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    // r1=0x100 r2=0x200 r5=0x1234 r9=0xCAFE0000 are written before the table.
    tbl[0]  = '{32'h00A5_3000, mk(6'h00, 5'd6,  32'h1234,     32'h1234, 0,            32'h100, 1, 1, 0)};
    tbl[1]  = '{32'h2024_FFF0, mk(6'h08, 5'd4,  32'h100,      0,        32'hFFFF_FFF0, 32'h104, 1, 0, 1)};
    tbl[2]  = '{32'h0A00_0000, mk(6'h02, 5'd0,  0,            0,        32'hFE00_0000, 32'h108, 0, 0, 1)};
    tbl[3]  = '{32'hA045_0008, mk(6'h28, 5'd0,  32'h200,      32'h1234, 32'h8,         32'h10C, 1, 1, 1)};
    tbl[4]  = '{32'h1123_8000, mk(6'h04, 5'd0,  32'hCAFE_0000, 0,       32'hFFFF_8000, 32'h110, 1, 0, 1)};
    tbl[5]  = '{32'hFC00_1234, mk(6'h3F, 5'd0,  0,            0,        0,             32'h114, 0, 0, 1)};
    tbl[6]  = '{32'h8023_0004, mk(6'h20, 5'd3,  32'h100,      0,        32'h4,         32'h118, 1, 0, 1)};
    tbl[7]  = '{32'h0022_5000, mk(6'h00, 5'd10, 32'h100,      32'h200,  0,             32'h11C, 1, 1, 0)};
    tbl[8]  = '{32'h200B_7FFF, mk(6'h08, 5'd11, 0,            0,        32'h7FFF,      32'h120, 1, 0, 1)};
    tbl[9]  = '{32'h8040_0010, mk(6'h20, 5'd0,  32'h200,      0,        32'h10,        32'h124, 1, 0, 1)};
    tbl[10] = '{32'h0000_0800, mk(6'h00, 5'd1,  0,            0,        0,             32'h128, 1, 1, 0)};

    drive(0, 0, 0);
    bus.freeze_in = 0;
    bus.flush_in  = 0;
    wb(0, 0, 0);
    reset = 1;
    tick();
    tick();
    check_zero("reset");
    reset = 0;

    wb(1, 5'd1, 32'h100);       tick();
    wb(1, 5'd2, 32'h200);       tick();
    wb(1, 5'd5, 32'h1234);      tick();
    wb(1, 5'd9, 32'hCAFE_0000); tick();
    wb(0, 0, 0);

    // Table: back-to-back issue with no load-use dependence.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].ins, tbl[i].e.npc, 1);
      sb.push_back(tbl[i].e);
      tick();
      chk("tbl_no_stall", 32'(bus.stall_out), 32'd0);
    end
    drive(0, 0, 0);
    tick();
    tick();
    chk("tbl_drained", 32'(sb.size()), 32'd0);

    // Load-use: exactly one stall cycle, one bubble, then the consumer.
    drive(32'h8023_0000, 32'h200, 1);
    sb.push_back(mk(6'h20, 5'd3, 32'h100, 0, 0, 32'h200, 1, 0, 1));
    tick();
    chk("lu_no_stall_yet", 32'(bus.stall_out), 32'd0);
    drive(32'h0023_6000, 32'h204, 1);
    sb.push_back(mk(6'h00, 5'd12, 32'h100, 0, 0, 32'h204, 1, 1, 0));
    tick();
    chk("lu_stall", 32'(bus.stall_out), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(bus.valid_out), 32'd0);
    chk("lu_stall_cleared", 32'(bus.stall_out), 32'd0);
    drive(0, 0, 0);
    tick();
    chk("lu_consumer_out", 32'(bus.valid_out), 32'd1);
    chk("lu_no_restall", 32'(bus.stall_out), 32'd0);

    // Write-through bypass on r7, then a write to r0 that must be ignored.
    drive(32'h20ED_0001, 32'h300, 1);
    sb.push_back(mk(6'h08, 5'd13, 32'hDEAD_BEEF, 0, 32'h1, 32'h300, 1, 0, 1));
    tick();
    drive(0, 0, 0);
    wb(1, 5'd7, 32'hDEAD_BEEF);
    tick();
    wb(0, 0, 0);
    drive(32'h200E_0002, 32'h304, 1);
    sb.push_back(mk(6'h08, 5'd14, 0, 0, 32'h2, 32'h304, 1, 0, 1));
    tick();
    drive(0, 0, 0);
    wb(1, 5'd0, 32'hFFFF_FFFF);
    tick();
    wb(0, 0, 0);
    drive(32'h0007_7800, 32'h308, 1);
    sb.push_back(mk(6'h00, 5'd15, 0, 32'hDEAD_BEEF, 0, 32'h308, 1, 1, 0));
    tick();
    drive(0, 0, 0);
    tick();
    chk("wb_drained", 32'(sb.size()), 32'd0);

    // Flush while a stall is pending.
    drive(32'h8023_0000, 32'h400, 1);
    sb.push_back(mk(6'h20, 5'd3, 32'h100, 0, 0, 32'h400, 1, 0, 1));
    tick();
    drive(32'h0023_6000, 32'h404, 1);
    tick();
    chk("fl_stall", 32'(bus.stall_out), 32'd1);
    bus.flush_in = 1;
    tick();
    bus.flush_in = 0;
    chk("fl_valid", 32'(bus.valid_out), 32'd0);
    chk("fl_stall_clear", 32'(bus.stall_out), 32'd0);
    drive(32'h00A5_3000, 32'h55, 1);
    sb.push_back(mk(6'h00, 5'd6, 32'h1234, 32'h1234, 0, 32'h55, 1, 1, 0));
    tick();
    drive(0, 0, 0);
    tick();
    chk("fl_drained", 32'(sb.size()), 32'd0);

    // Freeze: IF/ID content issues once, then bubbles until released.
    drive(32'h0022_5000, 32'h500, 1);
    sb.push_back(mk(6'h00, 5'd10, 32'h100, 32'h200, 0, 32'h500, 1, 1, 0));
    tick();
    bus.freeze_in = 1;
    drive(32'h200B_7FFF, 32'h504, 1);
    tick();
    chk("fz_issue", 32'(bus.valid_out), 32'd1);
    tick();
    chk("fz_no_dup", 32'(bus.valid_out), 32'd0);
    bus.freeze_in = 0;
    sb.push_back(mk(6'h08, 5'd11, 0, 0, 32'h7FFF, 32'h504, 1, 0, 1));
    tick();
    drive(0, 0, 0);
    tick();
    chk("fz_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stall with valid_in held high.
    drive(32'h8023_0000, 32'h600, 1);
    sb.push_back(mk(6'h20, 5'd3, 32'h100, 0, 0, 32'h600, 1, 0, 1));
    tick();
    drive(32'h0023_6000, 32'h604, 1);
    tick();
    chk("rs_stall", 32'(bus.stall_out), 32'd1);
    reset = 1;
    tick();
    check_zero("midreset");
    reset = 0;
    chk("rs_sb_empty", 32'(sb.size()), 32'd0);
    drive(32'h00A7_3000, 32'h700, 1);
    sb.push_back(mk(6'h00, 5'd6, 0, 0, 0, 32'h700, 1, 1, 0));
    tick();
    drive(0, 0, 0);
    tick();
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ins_decode_unit.md
Name: ins_decode_unit

Overview:
- Second pipeline stage, directly downstream of instruction fetch.
- Accepts the fetched instruction and its next-PC, and holds them in an IF/ID register.
- Decodes the fields and reads two operands from the internal register file, which has a write-back port.
- Registers the results into the ID/EX output register. Detects load-use hazards and stalls fetch. Honours pipeline freeze and flush.

Parameters:
- reg_width, 32, register-file data width
- bus_width, 32, instruction and PC width
- reg_count, 32, number of architectural registers; r0 reads as zero

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high
- ins_in  input  bus_width  instruction from fetch
- npc_in  input  bus_width  next-PC from fetch
- valid_in  input  1  ins_in/npc_in valid this cycle
- freeze_in  input  1  fetch freeze; no new capture into IF/ID
- flush_in  input  1  branch/jump taken downstream; kill IF/ID and ID/EX
- wb_en_in  input  1  register write enable
- wb_addr_in  input  $clog2(reg_count)  write address
- wb_data_in  input  reg_width  write data
- stall_out  output  1  to fetch wait_for_next_in; hold current instruction
- valid_out  output  1  ID/EX content valid
- opcode_out  output  6  ins[31:26]
- rd_out  output  5  destination register (0 if none)
- a_out  output  reg_width  rs1 operand
- b_out  output  reg_width  rs2 operand
- imm_out  output  reg_width  sign-extended immediate
- npc_out  output  bus_width  passed-through next-PC

Behaviour:
- Reset: synchronous, active-high. All outputs 0; IF/ID valid=0; all registers cleared to 0. Reset overrides every other input.
- Format: opcode=[31:26], rs1=[25:21], rs2=[20:16], rd_r=[15:11], imm16=[15:0], imm26=[25:0].
- Classes:
  - 0x00 R-ALU: uses rs1 and rs2; rd=rd_r.
  - 0x08 I-ALU: uses rs1; rd=[20:16]; imm=sext(imm16).
  - 0x20 LOAD: uses rs1; rd=[20:16]; imm=sext(imm16).
  - 0x28 STORE: uses rs1 and rs2; rd=0; imm=sext(imm16).
  - 0x04 BRANCH: uses rs1; rd=0; imm=sext(imm16).
  - 0x02 JUMP: uses neither; rd=0; imm=sext(imm26).
  - Any other opcode: treated as a NOP. It propagates with valid_out=1, rd=0, imm=0.
- IF/ID capture at a rising edge: load ins_in, npc_in, valid_in when !stall_out && !freeze_in. Otherwise hold.
- ID/EX update at every rising edge:
  - If stall_out=1: valid_out←0 (bubble). Other fields don't-care but must hold.
  - Otherwise: all fields ← decode of IF/ID; valid_out←IF/ID valid.
- Latency: instruction captured at edge N appears on outputs after edge N+1.
- Register read:
  - Combinational from IF/ID fields, registered into a_out/b_out.
  - Address 0 always reads 0.
  - Write-through bypass: if wb_en_in and wb_addr_in equals a read address (≠0) in the same cycle, the read returns wb_data_in.
- Register write: at the rising edge when wb_en_in=1 and wb_addr_in≠0. Writes to r0 are ignored.
- stall_out (combinational) = IF/ID valid && valid_out && opcode_out==LOAD && rd_out≠0 && (rd_out matches an rs field the IF/ID instruction uses).
  - Lasts exactly one cycle per hazard, because the inserted bubble clears it.
- flush_in at an edge: IF/ID valid←0 and valid_out←0.
  - Flush has priority over stall and over capture.
  - stall_out is 0 in the cycle after a flush.
- freeze_in: IF/ID holds its content. ID/EX still advances normally, so an instruction already in IF/ID is not duplicated.
  - Required fetch-side rule: while freeze_in is high, the decode unit presents a bubble once IF/ID has been consumed. IF/ID valid←0 after it is transferred.
- Simultaneous stall and freeze: stall governs ID/EX; freeze/stall both hold IF/ID.
- Reset mid-stall: everything clears at that edge; stall_out=0 in the following cycle.

Test Plan:
- Reset, then write r5=0x0000_1234 via wb. Feed R-ALU 0x00A5_3000 (rs1=5, rs2=5, rd=6) with npc=0x11 → after 2 edges: valid_out=1, a_out=b_out=0x1234, rd_out=6, npc_out=0x11.
- Feed I-ALU with imm16=0xFFF0 → imm_out=0xFFFF_FFF0. Feed JUMP with imm26=0x200_0000 → imm_out=0xFE00_0000.
- LOAD r3←[r1+0], then R-ALU using rs2=3 → stall_out=1 for exactly one cycle. One bubble appears (valid_out=0). The ALU instruction emerges next cycle with rd_out as encoded.
- wb_en=1, addr=7, data=0xDEAD_BEEF in the same cycle IF/ID reads rs1=7 → a_out=0xDEAD_BEEF. A wb to r0 leaves reads of r0 at 0.
- flush_in asserted while a stall is pending → next cycle valid_out=0, stall_out=0. A subsequently captured instruction decodes normally.
- Assert reset for one edge mid-stream with valid_in=1 → all outputs 0. Previously written registers read 0.
